// File: rtl/aes_pkg.sv
// Shared AES types: 32-bit word, 128-bit key as four words, round count, key-expand FSM states.
package aes_pkg;

  localparam int unsigned aes_word_width_lp = 32;
  localparam int unsigned aes_key_width_lp  = 128;
  localparam int unsigned aes_rounds_lp     = 10;
  localparam int unsigned aes_round_width_lp = 4;

  typedef logic [aes_word_width_lp-1:0] aes_word_t;

  // w0 occupies the most significant bits, matching key_i[127:96]
  typedef struct packed {
    aes_word_t w0;
    aes_word_t w1;
    aes_word_t w2;
    aes_word_t w3;
  } aes_key_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ke_state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub
);

  // Entry 0 is the leftmost byte of the constant
  localparam logic [0:255][7:0] sbox_lp = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = sbox_lp[val];

endmodule

// File: rtl/rom_rc.sv
// Round-constant ROM: address r (1..10) returns Rcon[r]; unused addresses read zero.
module rom_rc #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned addr_width_p = 4
) (
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    case (addr_i)
      addr_width_p'(1):  data_o = width_p'(8'h01);
      addr_width_p'(2):  data_o = width_p'(8'h02);
      addr_width_p'(3):  data_o = width_p'(8'h04);
      addr_width_p'(4):  data_o = width_p'(8'h08);
      addr_width_p'(5):  data_o = width_p'(8'h10);
      addr_width_p'(6):  data_o = width_p'(8'h20);
      addr_width_p'(7):  data_o = width_p'(8'h40);
      addr_width_p'(8):  data_o = width_p'(8'h80);
      addr_width_p'(9):  data_o = width_p'(8'h1b);
      addr_width_p'(10): data_o = width_p'(8'h36);
      default:           data_o = '0;
    endcase
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: latches one cipher key, then streams round keys 0..10 under yumi handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned key_width_p     = aes_key_width_lp,
  parameter int unsigned rounds_p        = aes_rounds_lp,
  parameter int unsigned rc_addr_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [key_width_p-1:0] key_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [key_width_p-1:0] rkey_o,
  output logic [3:0]             round_o,
  output logic                   v_o,
  input  logic                   yumi_i
);

  localparam int unsigned round_w_lp = aes_round_width_lp;

  ke_state_e               state_r, state_n;
  logic [round_w_lp-1:0]   round_r;
  aes_key_t                rk_r, rk_next;
  logic                    load, adv;
  logic [rc_addr_width_p-1:0] rc_addr;
  logic [7:0]              rcon;
  aes_word_t               rot, sub, t;

  // Rcon for the key being produced next is indexed by round_r+1
  assign rc_addr = rc_addr_width_p'(round_r + round_w_lp'(1));

  rom_rc #(.width_p(8), .addr_width_p(rc_addr_width_p)) u_rom_rc (
    .addr_i (rc_addr),
    .data_o (rcon)
  );

  assign rot = {rk_r.w3[23:0], rk_r.w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .val (rot[8*i +: 8]),
      .sub (sub[8*i +: 8])
    );
  end

  // Next round key: XOR chain seeded by SubWord(RotWord(w3)) ^ Rcon
  always_comb begin
    t          = sub ^ {rcon, 24'h0};
    rk_next.w0 = rk_r.w0 ^ t;
    rk_next.w1 = rk_r.w1 ^ rk_next.w0;
    rk_next.w2 = rk_r.w2 ^ rk_next.w1;
    rk_next.w3 = rk_r.w3 ^ rk_next.w2;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_r)
      IDLE: begin
        if (v_i) begin
          load    = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (yumi_i) begin
          if (round_r == round_w_lp'(rounds_p)) state_n = IDLE;
          else                                  adv     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Key and round index only move on load or an accepted beat, so stalls hold outputs steady
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rk_r    <= '0;
      round_r <= '0;
    end else if (load) begin
      rk_r    <= aes_key_t'(key_i);
      round_r <= '0;
    end else if (adv) begin
      rk_r    <= rk_next;
      round_r <= round_r + round_w_lp'(1);
    end
  end

  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    rkey_o  = key_width_p'(rk_r);
    round_o = round_r;
    case (state_r)
      IDLE:    ready_o = 1'b1;
      EMIT:    v_o     = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 and all-zero key schedules, stalls, overlap, reset abort.
module tb_aes_key_expand;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] rkey;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [127:0] key_i;
  logic         v_i;
  logic         ready_o;
  logic [127:0] rkey_o;
  logic [3:0]   round_o;
  logic         v_o;
  logic         yumi_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = -100;
  int last_cyc = -100;

  exp_t sb[$];
  logic [127:0] fips_tab [0:10];
  logic [127:0] zero_tab [0:10];

  bit  yumi_en   = 1'b0;
  int  stall_pct = 0;

  logic         prev_v;
  logic         prev_yumi;
  logic [127:0] prev_rkey;
  logic [3:0]   prev_round;

  localparam logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] zero_key = 128'h0;

  aes_key_expand dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .key_i   (key_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .rkey_o  (rkey_o),
    .round_o (round_o),
    .v_o     (v_o),
    .yumi_i  (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected schedule is queued when the DUT is about to accept a key
  always @(negedge clk_i) begin
    if (!reset_i && v_i && ready_o) begin
      for (int r = 0; r <= 10; r++) begin
        exp_t e;
        e.round = 4'(r);
        e.rkey  = (key_i == fips_key) ? fips_tab[r] : zero_tab[r];
        sb.push_back(e);
      end
      acc_cyc = cyc;
    end
  end

  // Monitor: compares accepted beats, stall stability and ROM addressing
  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_v    = 1'b0;
      prev_yumi = 1'b0;
    end else begin
      if (v_o && prev_v && !prev_yumi) begin
        check("stall_rkey", rkey_o, prev_rkey);
        check("stall_round", 128'(round_o), 128'(prev_round));
      end
      if (yumi_i && !v_o) begin
        checks++;
        errors++;
        $display("FAIL yumi_without_v: yumi_i=1 while v_o=0 (cycle %0d)", cyc);
      end
      if (v_o && yumi_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: round %0d with empty scoreboard", round_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("round", 128'(round_o), 128'(e.round));
          check("rkey", rkey_o, e.rkey);
          if (e.round < 4'd10)
            check("rc_addr", 128'(dut.rc_addr), 128'(e.round + 4'd1));
          if (e.round == 4'd10) last_cyc = cyc;
        end
      end
      prev_v     = v_o;
      prev_yumi  = yumi_i;
      prev_rkey  = rkey_o;
      prev_round = round_o;
    end
  end

  // Consumer: random back-pressure, never asserts yumi without valid
  initial begin
    yumi_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      yumi_i = yumi_en && v_o && !reset_i && (int'($urandom_range(99)) >= stall_pct);
    end
  end

  task automatic load_key(input logic [127:0] k);
    int n;
    key_i = k;
    v_i   = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (ready_o) break;
      @(posedge clk_i);
      #1;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: ready_o never rose for key %h", k);
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 300; n++) begin
      if (sb.size() == 0 && !v_o) break;
      @(posedge clk_i);
      #1;
    end
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    fips_tab[0]  = fips_key;
    fips_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_tab[0]  = zero_key;
    zero_tab[1]  = 128'h62636363626363636263636362636363;
    zero_tab[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_tab[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_tab[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_tab[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_tab[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_tab[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_tab[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_tab[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_tab[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    reset_i = 1'b1;
    v_i     = 1'b0;
    key_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready", 128'(ready_o), 128'(1));
    check("reset_v", 128'(v_o), 128'(0));
    check("reset_round", 128'(round_o), 128'(0));
    check("reset_rkey", rkey_o, 128'h0);
    reset_i = 1'b0;
    yumi_en = 1'b1;

    // Full-rate FIPS-197 schedule
    stall_pct = 0;
    load_key(fips_key);
    wait_drain();

    // Same schedule under back-pressure
    stall_pct = 30;
    load_key(fips_key);
    wait_drain();

    // All-zero key
    stall_pct = 0;
    load_key(zero_key);
    wait_drain();

    // Second key presented while streaming; accepted the cycle after round 10 is taken
    stall_pct = 20;
    load_key(fips_key);
    load_key(zero_key);
    check("accept_after_last", 128'(acc_cyc - last_cyc), 128'(1));
    wait_drain();

    // Asynchronous reset in the middle of a stream
    stall_pct = 0;
    load_key(fips_key);
    begin
      int n;
      for (n = 0; n < 100; n++) begin
        if (v_o && round_o == 4'd5) break;
        @(posedge clk_i);
        #1;
      end
      check("reach_round5", 128'(round_o), 128'(5));
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_ready", 128'(ready_o), 128'(1));
    check("abort_v", 128'(v_o), 128'(0));
    check("abort_round", 128'(round_o), 128'(0));
    check("abort_rkey", rkey_o, 128'h0);
    sb.delete();
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    load_key(fips_key);
    wait_drain();

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
